// File: rtl/xfer_link_arbiter.sv
// xfer_link_arbiter: two-scanner round-robin arbiter serializing command/payload frames onto a slot-aligned link
//   clk, rst (async, active-high)
//   req[1:0]                 level requests, held until done
//   cmd0/cmd1                command bytes per scanner
//   payload0/payload1        payload bytes, sent only after data commands
//   link_ready               transfer center can accept a frame
//   grant[1:0]               one-hot owner of the frame in progress
//   done[1:0]                one-cycle pulse to owner on the last bit
//   serial_out               MSB-first link bit, 0 while idle
//   frame_sync               high on the MSB cycle of each command byte
//   busy                     frame in progress
//   XFER_FIXED_PRIO_EN       when defined, scanner 0 wins every contested arbitration
module xfer_link_arbiter #(
  parameter int BYTE_W = 8,
  parameter logic [BYTE_W-1:0] DATA_CMD_A = BYTE_W'(7),
  parameter logic [BYTE_W-1:0] DATA_CMD_B = BYTE_W'(8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [BYTE_W-1:0] cmd0,
  input  logic [BYTE_W-1:0] cmd1,
  input  logic [BYTE_W-1:0] payload0,
  input  logic [BYTE_W-1:0] payload1,
  input  logic              link_ready,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              serial_out,
  output logic              frame_sync,
  output logic              busy
);
  localparam int CW = $clog2(BYTE_W);
  localparam logic [CW-1:0] LAST = CW'(BYTE_W - 1);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_n;
  logic [CW-1:0] slot_cnt;
  logic [BYTE_W-1:0] sr, pay_q, cmd_sel, pay_sel;
  logic is_data, last_owner, winner, start, slot_end;
  always_comb begin
    slot_end = slot_cnt == LAST;
`ifdef XFER_FIXED_PRIO_EN
    winner = !req[0];
`else
    // the scanner that did not own the previous frame gets first refusal
    winner = req[!last_owner] ? !last_owner : last_owner;
`endif
    cmd_sel = winner ? cmd1 : cmd0;
    pay_sel = winner ? payload1 : payload0;
    // only idle slot boundaries arbitrate, so a finished frame is always followed by a full 0x00 slot
    start = state == IDLE && slot_end && |req && link_ready;
    state_n = start ? CMD :
              (state == CMD && slot_end) ? (is_data ? DATA : IDLE) :
              (state == DATA && slot_end) ? IDLE : state;
    done = (slot_end && (state == DATA || (state == CMD && !is_data))) ? grant : 2'b00;
    serial_out = state != IDLE && sr[BYTE_W-1];
    frame_sync = state == CMD && slot_cnt == '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      state <= IDLE;
      sr <= '0;
      pay_q <= '0;
      is_data <= 1'b0;
      grant <= 2'b00;
      last_owner <= 1'b1;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
      state <= state_n;
      if (start) begin
        sr <= cmd_sel;
        pay_q <= pay_sel;
        is_data <= cmd_sel == DATA_CMD_A || cmd_sel == DATA_CMD_B;
        grant <= winner ? 2'b10 : 2'b01;
        last_owner <= winner;
      end else if (state == CMD && slot_end && is_data) begin
        sr <= pay_q;
      end else if (state != IDLE) begin
        sr <= sr << 1;
      end
      if (|done) grant <= 2'b00;
    end
  end
endmodule

// File: tb/tb_xfer_link_arbiter.sv
// tb_xfer_link_arbiter: scoreboard bench comparing every link cycle against a frame-level reference model
module tb_xfer_link_arbiter;
  logic clk = 1'b0, rst = 1'b1, link_ready = 1'b0, serial_out, frame_sync, busy;
  logic [1:0] req = 2'b00, grant, done;
  logic [7:0] cmd0 = '0, cmd1 = '0, payload0 = '0, payload1 = '0;
  typedef struct packed {logic ser; logic fs; logic busy; logic [1:0] grant; logic [1:0] done;} rec_t;
  rec_t exp_q[$];
  int vectors = 0, errors = 0, c = 0;
  logic m_last = 1'b1, active = 1'b0;

  xfer_link_arbiter dut (.clk(clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1),
    .payload0(payload0), .payload1(payload1), .link_ready(link_ready), .grant(grant),
    .done(done), .serial_out(serial_out), .frame_sync(frame_sync), .busy(busy));

  always #5 clk = ~clk;

  // Reference: the link is a sequence of byte slots; an idle slot boundary with a ready link and a
  // request emits a whole frame (command byte, plus payload byte for data commands) into the future.
  task automatic model_step();
    rec_t r;
    logic w;
    logic [7:0] cb, pb;
    int n;
    if (exp_q.size() == 0) begin
      exp_q.push_back('0);
      if (c % 8 == 7 && |req && link_ready) begin
`ifdef XFER_FIXED_PRIO_EN
        w = !req[0];
`else
        w = req[!m_last] ? !m_last : m_last;
`endif
        m_last = w;
        cb = w ? cmd1 : cmd0;
        pb = w ? payload1 : payload0;
        n = (cb == 8'd7 || cb == 8'd8) ? 16 : 8;
        for (int i = 0; i < n; i++) begin
          r.ser = i < 8 ? cb[7-i] : pb[15-i];
          r.fs = i == 0;
          r.busy = 1'b1;
          r.grant = w ? 2'b10 : 2'b01;
          r.done = i == n - 1 ? r.grant : 2'b00;
          exp_q.push_back(r);
        end
      end
    end
  endtask

  // entered and left at posedge+1; inputs for this cycle are already applied
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      #1 model_step();
      c++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({serial_out, frame_sync, busy, grant, done} !== 7'b0) begin
      errors++;
      $display("FAIL %s: got ser=%b fs=%b busy=%b grant=%b done=%b, expected all zero", name,
               serial_out, frame_sync, busy, grant, done);
    end
  endtask

  task automatic release_rst();
    rst = 1'b0;
    c = 0;
    m_last = 1'b1;
    exp_q.delete();
    active = 1'b1;
  endtask

  always @(negedge clk) begin
    rec_t a, e;
    if (active && !rst) begin
      a = {serial_out, frame_sync, busy, grant, done};
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow cycle %0d: got %b, expected nothing queued", c, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL link cycle %0d {ser,fs,busy,grant,done}: got %b, expected %b", c, a, e);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    link_ready = 1'b1; req = 2'b01; cmd0 = 8'h03;
    release_rst();
    step(16);
    req = 2'b10; cmd1 = 8'h07; payload1 = 8'hA5;
    step(32);
    req = 2'b11; cmd0 = 8'h01; cmd1 = 8'h02;
    step(56);
    req = 2'b01; link_ready = 1'b0;
    step(24);
    link_ready = 1'b1;
    step(24);
    req = 2'b00;
    step(8);
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(3) == 0) req = 2'($urandom);
      link_ready = $urandom_range(4) != 0;
      cmd0 = ($urandom_range(2) == 0) ? 8'd7 + 8'($urandom_range(1)) : 8'($urandom);
      cmd1 = ($urandom_range(2) == 0) ? 8'd7 + 8'($urandom_range(1)) : 8'($urandom);
      payload0 = 8'($urandom);
      payload1 = 8'($urandom);
      step(1);
    end
    req = 2'b01; cmd0 = 8'h08; payload0 = 8'h5A; link_ready = 1'b1;
    for (int k = 0; k < 64 && exp_q.size() < 10; k++) step(1);
    step(3);
    #2 rst = 1'b1;
    active = 1'b0;
    #1 check_zero("async reset mid-frame");
    @(posedge clk);
    #1 check_zero("reset held");
    @(posedge clk);
    #1 check_zero("reset held 2");
    cmd0 = 8'hC3;
    release_rst();
    step(40);
    for (int k = 0; k < 400; k++) begin
      req = 2'($urandom);
      link_ready = $urandom_range(3) != 0;
      cmd0 = 8'($urandom_range(9));
      cmd1 = 8'($urandom_range(9));
      payload0 = 8'($urandom);
      payload1 = 8'($urandom);
      step(1);
    end
    active = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
